output_layer_mac: RTL and testbench

//  Sequential multiply-accumulate engine for the NN output layer; directly feeds the argmax classifier.
//  One shared MAC computes each output node's dot product: stored weights x hidden-layer activations.

---
 rtl/nn_pkg.sv | 29 ++
 rtl/mac_sat_unit.sv | 37 +++
 rtl/output_layer_mac.sv | 170 +++++++++++++++++
 tb/tb_output_layer_mac.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types, Q8 limits and saturation helper for the NN datapath
// (used by the output-layer MAC and the argmax classifier).
package nn_pkg;

  typedef logic signed [7:0] q8_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    STORE,
    DONE
  } mac_state_t;

  localparam q8_t Q8_MIN = 8'sh80;
  localparam q8_t Q8_MAX = 8'sh7f;

  // Clamp a signed value (already scaled) into the signed 8-bit range.
  function automatic q8_t sat8(input logic signed [31:0] x);
    if (x > 32'sd127) begin
      return Q8_MAX;
    end else if (x < -32'sd128) begin
      return Q8_MIN;
    end else begin
      return q8_t'(x[7:0]);
    end
  endfunction

endpackage

// File: rtl/mac_sat_unit.sv
// Accumulator with clear/enable; its value is continuously scaled by an
// arithmetic right shift and saturated to signed 8 bit.
module mac_sat_unit
  import nn_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int SHIFT = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic signed [15:0]  prod,
  output q8_t                 sat_out
);

  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_shifted;
  logic signed [31:0]      acc_shifted_ext;

  // Clear wins over accumulate so STORE can drop the finished sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg + ACC_W'(prod);
    end
  end

  // Arithmetic shift floors toward -inf, matching Q1.7 truncation.
  assign acc_shifted     = acc_reg >>> SHIFT;
  assign acc_shifted_ext = 32'(acc_shifted);
  assign sat_out         = sat8(acc_shifted_ext);

endmodule

// File: rtl/output_layer_mac.sv
// Output-layer MAC: walks nodes x inputs through one shared multiply-accumulate
// and leaves one saturated Q8 result per node for the argmax classifier.
module output_layer_mac
  import nn_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int ACC_W = 24,
  parameter int SHIFT = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] outputNodeNumber,
  input  logic [4:0] numInputs,
  output logic [7:0] weight_addr,
  input  logic [7:0] weight_data,
  output logic [3:0] act_addr,
  input  logic [7:0] act_data,
  output logic [7:0] result0,
  output logic [7:0] result1,
  output logic [7:0] result2,
  output logic [7:0] result3,
  output logic [7:0] result4,
  output logic [7:0] result5,
  output logic [7:0] result6,
  output logic [7:0] result7,
  output logic [7:0] result8,
  output logic [7:0] result9,
  output logic [7:0] result10,
  output logic [7:0] result11,
  output logic [7:0] result12,
  output logic [7:0] result13,
  output logic [7:0] result14,
  output logic [7:0] result15,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] N_IN_W = 8'(N_IN);
  localparam logic [4:0] N_IN_5 = 5'(N_IN);

  mac_state_t  state_reg, state_next;
  logic [3:0]  j_reg, j_next;
  logic [3:0]  i_reg, i_next;
  logic [4:0]  nn_reg, nn_next;
  logic [4:0]  ni_reg, ni_next;
  logic        rd_valid_reg, rd_valid_next;
  logic        done_reg;
  logic        acc_clr;
  logic        acc_en;
  logic        store_en;
  logic signed [15:0] prod;
  q8_t         sat_out;
  q8_t         result_reg [16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      j_reg        <= '0;
      i_reg        <= '0;
      nn_reg       <= '0;
      ni_reg       <= '0;
      rd_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      j_reg        <= j_next;
      i_reg        <= i_next;
      nn_reg       <= nn_next;
      ni_reg       <= ni_next;
      rd_valid_reg <= rd_valid_next;
      done_reg     <= (state_reg == DONE);
    end
  end

  always_comb begin
    state_next    = state_reg;
    j_next        = j_reg;
    i_next        = i_reg;
    nn_next       = nn_reg;
    ni_next       = ni_reg;
    rd_valid_next = (state_reg == RUN);
    acc_clr       = 1'b0;
    acc_en        = rd_valid_reg;
    store_en      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          nn_next    = (outputNodeNumber == 4'd0) ? 5'd16 : {1'b0, outputNodeNumber};
          ni_next    = (numInputs == 5'd0 || numInputs > N_IN_5) ? N_IN_5 : numInputs;
          j_next     = '0;
          i_next     = '0;
          acc_clr    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (i_reg == 4'(ni_reg - 5'd1)) begin
          state_next = DRAIN;
        end else begin
          i_next = i_reg + 4'd1;
        end
      end
      DRAIN: state_next = STORE;
      STORE: begin
        store_en = 1'b1;
        acc_clr  = 1'b1;
        i_next   = '0;
        if ({1'b0, j_reg} == nn_reg - 5'd1) begin
          state_next = DONE;
        end else begin
          j_next     = j_reg + 4'd1;
          state_next = RUN;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign prod = $signed(weight_data) * $signed(act_data);

  mac_sat_unit #(
    .ACC_W(ACC_W),
    .SHIFT(SHIFT)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (acc_clr),
    .en     (acc_en),
    .prod   (prod),
    .sat_out(sat_out)
  );

  // Unused node slots are forced to Q8_MIN so argmax never selects them.
  for (genvar gi = 0; gi < 16; gi++) begin : g_result
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        result_reg[gi] <= Q8_MIN;
      end else if (store_en && j_reg == 4'(gi)) begin
        result_reg[gi] <= sat_out;
      end else if (state_reg == DONE && 5'(gi) >= nn_reg) begin
        result_reg[gi] <= Q8_MIN;
      end
    end
  end

  assign weight_addr = (state_reg == RUN) ? (8'(j_reg) * N_IN_W + 8'(i_reg)) : 8'd0;
  assign act_addr    = (state_reg == RUN) ? i_reg : 4'd0;
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;

  assign result0  = result_reg[0];
  assign result1  = result_reg[1];
  assign result2  = result_reg[2];
  assign result3  = result_reg[3];
  assign result4  = result_reg[4];
  assign result5  = result_reg[5];
  assign result6  = result_reg[6];
  assign result7  = result_reg[7];
  assign result8  = result_reg[8];
  assign result9  = result_reg[9];
  assign result10 = result_reg[10];
  assign result11 = result_reg[11];
  assign result12 = result_reg[12];
  assign result13 = result_reg[13];
  assign result14 = result_reg[14];
  assign result15 = result_reg[15];

endmodule

// File: tb/tb_output_layer_mac.sv
// Directed bench for output_layer_mac: latency, scaling/saturation, neutral
// fill of unused nodes, ignored restarts and asynchronous reset.
module tb_output_layer_mac;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] outputNodeNumber;
  logic [4:0] numInputs;
  logic [7:0] weight_addr;
  logic [7:0] weight_data;
  logic [3:0] act_addr;
  logic [7:0] act_data;
  logic [7:0] res [16];
  logic       busy;
  logic       done;

  logic [7:0] wmem [256];
  logic [7:0] amem [16];
  logic [7:0] exp_res [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Synchronous-read memories: data valid one cycle after the address.
  always @(posedge clk) begin
    weight_data <= wmem[weight_addr];
    act_data    <= amem[act_addr];
  end

  output_layer_mac dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .outputNodeNumber(outputNodeNumber),
    .numInputs       (numInputs),
    .weight_addr     (weight_addr),
    .weight_data     (weight_data),
    .act_addr        (act_addr),
    .act_data        (act_data),
    .result0         (res[0]),
    .result1         (res[1]),
    .result2         (res[2]),
    .result3         (res[3]),
    .result4         (res[4]),
    .result5         (res[5]),
    .result6         (res[6]),
    .result7         (res[7]),
    .result8         (res[8]),
    .result9         (res[9]),
    .result10        (res[10]),
    .result11        (res[11]),
    .result12        (res[12]),
    .result13        (res[13]),
    .result14        (res[14]),
    .result15        (res[15]),
    .busy            (busy),
    .done            (done)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_results(input string tag);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_r%0d", tag, k), {8'h00, res[k]}, {8'h00, exp_res[k]});
    end
    $display("%s: results r0=%0d r1=%0d r2=%0d r15=%0d", tag,
             $signed(res[0]), $signed(res[1]), $signed(res[2]), $signed(res[15]));
  endtask

  task automatic fill_all(input logic [7:0] w, input logic [7:0] a);
    for (int k = 0; k < 256; k++) wmem[k] = w;
    for (int k = 0; k < 16; k++) amem[k] = a;
  endtask

  // Start is driven in cycle 0; done must be seen in cycle exp_lat.
  task automatic run_layer(input string tag, input logic [3:0] onn, input logic [4:0] ni,
                           input int exp_lat, input bit glitch);
    int cnt;
    @(negedge clk);
    outputNodeNumber = onn;
    numInputs        = ni;
    start            = 1'b1;
    cnt              = 0;
    do begin
      @(negedge clk);
      cnt++;
      start = 1'b0;
      if (cnt == 1) chk({tag, "_busy1"}, {15'd0, busy}, 16'd1);
      if (glitch && cnt == 3) begin
        start            = 1'b1;
        outputNodeNumber = 4'd1;
        numInputs        = 5'd1;
      end
    end while (done !== 1'b1 && cnt < 400);
    start = 1'b0;
    chk({tag, "_latency"}, 16'(cnt), 16'(exp_lat));
    $display("%s: done after %0d cycles", tag, cnt);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {15'd0, done}, 16'd0);
    chk({tag, "_busy_idle"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    int done_seen;
    reset            = 1'b1;
    start            = 1'b0;
    outputNodeNumber = 4'd0;
    numInputs        = 5'd0;
    fill_all(8'd0, 8'd0);
    for (int k = 0; k < 16; k++) exp_res[k] = 8'h80;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_waddr", {8'd0, weight_addr}, 16'd0);
    chk("rst_aaddr", {12'd0, act_addr}, 16'd0);
    chk_results("reset");
    reset = 1'b0;

    // NN=3 NI=4, w=32 a=16: acc 2048 >>> 7 = 16
    fill_all(8'd32, 8'd16);
    run_layer("nn3_ni4", 4'd3, 5'd4, 20, 1'b0);
    for (int k = 0; k < 16; k++) exp_res[k] = (k < 3) ? 8'd16 : 8'h80;
    chk_results("nn3_ni4");

    // Asynchronous reset between clock edges clears loaded results at once
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 16; k++) exp_res[k] = 8'h80;
    chk("async_busy", {15'd0, busy}, 16'd0);
    chk("async_done", {15'd0, done}, 16'd0);
    chk_results("async_rst");
    @(negedge clk);
    reset = 1'b0;

    // Positive saturation: 16*127*127 = 258064 -> 2016 -> 127
    fill_all(8'd127, 8'd127);
    run_layer("sat_pos", 4'd1, 5'd16, 20, 1'b0);
    exp_res[0] = 8'd127;
    chk_results("sat_pos");

    // Negative saturation: 16*(-128)*127 = -260096 -> -2032 -> -128
    fill_all(8'h80, 8'd127);
    run_layer("sat_neg", 4'd1, 5'd16, 20, 1'b0);
    exp_res[0] = 8'h80;
    chk_results("sat_neg");

    // Floor toward -inf: acc -1 -> -1; acc 128 -> 1. Activations are shared by
    // all nodes, so node 0 uses weights {-1,0} with activations {1,1}.
    fill_all(8'h55, 8'h55);
    wmem[0]  = 8'hff;
    wmem[1]  = 8'h00;
    wmem[16] = 8'd64;
    wmem[17] = 8'd64;
    amem[0]  = 8'd1;
    amem[1]  = 8'd1;
    run_layer("nn2_ni2", 4'd2, 5'd2, 10, 1'b0);
    exp_res[0] = 8'hff;
    exp_res[1] = 8'h01;
    chk_results("nn2_ni2");

    // Restart attempt and input change 3 cycles into a run are ignored
    fill_all(8'd32, 8'd16);
    run_layer("restart", 4'd3, 5'd4, 20, 1'b1);
    for (int k = 0; k < 16; k++) exp_res[k] = (k < 3) ? 8'd16 : 8'h80;
    chk_results("restart");

    // Reset mid-run: abort, results back to -128, no done pulse afterwards
    @(negedge clk);
    outputNodeNumber = 4'd3;
    numInputs        = 5'd4;
    start            = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 16; k++) exp_res[k] = 8'h80;
    chk("midrst_busy", {15'd0, busy}, 16'd0);
    chk_results("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    chk("midrst_no_done", 16'(done_seen), 16'd0);

    // NN=0 -> 16 nodes, NI=0 -> 16 inputs; node n weights n+1, acts 8 -> n+1
    for (int n = 0; n < 16; n++)
      for (int i = 0; i < 16; i++) wmem[n*16+i] = 8'(n + 1);
    for (int i = 0; i < 16; i++) amem[i] = 8'd8;
    run_layer("full16", 4'd0, 5'd0, 290, 1'b0);
    for (int k = 0; k < 16; k++) exp_res[k] = 8'(k + 1);
    chk_results("full16");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
